uart_telemetry_ctrl: RTL and testbench

Parametrised command parser and telemetry framer between the byte-level UART core and the acquisition channels. Decodes checksummed command frames from the host, returns framed multi-channel snapshots, streams one selected channel on every sample strobe, forwards register writes, and reports incident events. It is the N-channel, framed, error-counting successor to the fixed two-ADS UART control block.

---
 rtl/uart_telemetry_ctrl_if.sv | 32 +++
 rtl/uart_telemetry_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_telemetry_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_telemetry_ctrl_if.sv
// Byte-level UART, acquisition channel, register-write and incident signals of the telemetry controller.
interface uart_telemetry_ctrl_if #(
   parameter int NUM_CH = 8,
   parameter int CH_W   = 16
) ();
   logic                     rx_valid;
   logic [7:0]               rx_data;
   logic                     tx_ready;
   logic                     tx_valid;
   logic [7:0]               tx_data;
   logic [NUM_CH*CH_W-1:0]   ch_data;
   logic [NUM_CH-1:0]        ch_en;
   logic                     cfg_wr;
   logic [7:0]               cfg_addr;
   logic [7:0]               cfg_data;
   logic                     event_valid;
   logic [31:0]              event_data;
   logic                     event_ack;
   logic                     busy;
   logic [7:0]               err_cnt;
   logic [7:0]               drop_cnt;

   modport master (
      output rx_valid, rx_data, tx_ready, ch_data, ch_en, event_valid, event_data,
      input  tx_valid, tx_data, cfg_wr, cfg_addr, cfg_data, event_ack, busy, err_cnt, drop_cnt
   );

   modport slave (
      input  rx_valid, rx_data, tx_ready, ch_data, ch_en, event_valid, event_data,
      output tx_valid, tx_data, cfg_wr, cfg_addr, cfg_data, event_ack, busy, err_cnt, drop_cnt
   );
endinterface

// File: rtl/uart_telemetry_ctrl.sv
// Command parser and telemetry framer; commands act the cycle after their CHK byte, first SYNC one cycle after a
// TX trigger. tx_data is held while tx_ready is low; excess snapshot requests and stream samples are counted and dropped.
module uart_telemetry_ctrl #(
   parameter int         NUM_CH  = 8,
   parameter int         CH_W    = 16,
   parameter logic [7:0] SYNC    = 8'hAA,
   parameter int         TIMEOUT = 100000
) (
   input logic                  clk,
   input logic                  rst,
   uart_telemetry_ctrl_if.slave bus
);
   localparam int CH_B   = CH_W / 8;
   localparam int SNAP_W = NUM_CH * CH_W;
   localparam int BUF_W  = (SNAP_W > 32) ? SNAP_W : 32;
   localparam int TMO_W  = $clog2(TIMEOUT + 1);
   localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {R_IDLE, R_PAY, R_CHK} rx_st_t;
   typedef enum logic [2:0] {T_IDLE, T_SYNC, T_ID, T_DATA, T_CHK} tx_st_t;

   rx_st_t             r_rx_st, w_rx_nxt;
   logic [7:0]         r_op, r_pay0, r_pay1, r_sum;
   logic               r_pidx;
   logic [TMO_W-1:0]   r_tmo;
   logic               w_rx_err, w_frame_ok, w_tmo_exp, w_pay_last, w_idx_ok;

   tx_st_t             r_tx_st, w_tx_nxt;
   logic [BUF_W-1:0]   r_tx_buf;
   logic [7:0]         r_tx_id, r_tx_sum, r_tx_left, w_tx_dat;
   logic               w_start_snap, w_start_evt, w_start_str;

   logic               r_cfg_wr, r_stream_en, r_snap_pend, r_str_pend;
   logic [7:0]         r_cfg_addr, r_cfg_data, r_err_cnt, r_drop_cnt;
   logic [SEL_W-1:0]   r_stream_ch;
   logic [CH_W-1:0]    r_str_dat;
   logic               w_cmd_snap, w_strobe, w_snap_drop, w_str_drop;

   function automatic logic [1:0] pay_len(input logic [7:0] op);
      case (op)
         8'h11:   pay_len = 2'd2;
         8'h44:   pay_len = 2'd1;
         default: pay_len = 2'd0;
      endcase
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [1:0] inc);
      logic [8:0] s;
      s = {1'b0, c} + {7'd0, inc};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   assign w_pay_last = (pay_len(r_op) == 2'd2) ? r_pidx : 1'b1;
   assign w_idx_ok   = (r_op != 8'h44) || ({24'd0, r_pay0} < 32'(NUM_CH));
   // A byte arriving in the expiry cycle wins over the timeout.
   assign w_tmo_exp  = (r_rx_st != R_IDLE) && !bus.rx_valid && (r_tmo == TMO_W'(TIMEOUT - 1));

   always_comb begin
      w_rx_nxt   = r_rx_st;
      w_rx_err   = 1'b0;
      w_frame_ok = 1'b0;
      case (r_rx_st)
         R_IDLE: if (bus.rx_valid) begin
            if (bus.rx_data inside {8'h01, 8'h11, 8'h44, 8'h45})
               w_rx_nxt = (pay_len(bus.rx_data) == 2'd0) ? R_CHK : R_PAY;
            else
               w_rx_err = 1'b1;
         end
         R_PAY: if (bus.rx_valid) begin
            if (w_pay_last) w_rx_nxt = R_CHK;
         end else if (w_tmo_exp) begin
            w_rx_err = 1'b1;
            w_rx_nxt = R_IDLE;
         end
         R_CHK: if (bus.rx_valid) begin
            w_rx_nxt = R_IDLE;
            if ((bus.rx_data == r_sum) && w_idx_ok) w_frame_ok = 1'b1;
            else                                    w_rx_err   = 1'b1;
         end else if (w_tmo_exp) begin
            w_rx_err = 1'b1;
            w_rx_nxt = R_IDLE;
         end
         default: w_rx_nxt = R_IDLE;
      endcase
   end

   assign w_cmd_snap  = w_frame_ok && (r_op == 8'h01);
   assign w_snap_drop = w_cmd_snap && r_snap_pend && !w_start_snap;
   assign w_strobe    = r_stream_en && bus.ch_en[r_stream_ch];
   assign w_str_drop  = w_strobe && r_str_pend && !w_start_str;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_st <= R_IDLE;
         r_op    <= '0;
         r_pay0  <= '0;
         r_pay1  <= '0;
         r_sum   <= '0;
         r_pidx  <= 1'b0;
         r_tmo   <= '0;
      end else begin
         r_rx_st <= w_rx_nxt;
         r_tmo   <= (bus.rx_valid || r_rx_st == R_IDLE) ? '0 : r_tmo + 1'b1;
         if (bus.rx_valid) begin
            if (r_rx_st == R_IDLE) begin
               r_op   <= bus.rx_data;
               r_sum  <= bus.rx_data;
               r_pidx <= 1'b0;
            end else if (r_rx_st == R_PAY) begin
               r_sum  <= r_sum + bus.rx_data;
               r_pidx <= 1'b1;
               if (r_pidx) r_pay1 <= bus.rx_data;
               else        r_pay0 <= bus.rx_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cfg_wr    <= 1'b0;
         r_cfg_addr  <= '0;
         r_cfg_data  <= '0;
         r_stream_en <= 1'b0;
         r_stream_ch <= '0;
         r_snap_pend <= 1'b0;
         r_str_pend  <= 1'b0;
         r_str_dat   <= '0;
         r_err_cnt   <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_cfg_wr <= w_frame_ok && (r_op == 8'h11);
         if (w_frame_ok && (r_op == 8'h11)) begin
            r_cfg_addr <= r_pay0;
            r_cfg_data <= r_pay1;
         end
         if (w_frame_ok && (r_op == 8'h44)) begin
            r_stream_en <= 1'b1;
            r_stream_ch <= r_pay0[SEL_W-1:0];
         end else if (w_frame_ok && (r_op == 8'h45)) begin
            r_stream_en <= 1'b0;
         end
         r_snap_pend <= (r_snap_pend && !w_start_snap) || w_cmd_snap;
         r_str_pend  <= (r_str_pend && !w_start_str) || w_strobe;
         if (w_strobe && !w_str_drop) r_str_dat <= bus.ch_data[r_stream_ch*CH_W +: CH_W];
         r_err_cnt  <= sat_add(r_err_cnt, {1'b0, w_rx_err});
         r_drop_cnt <= sat_add(r_drop_cnt, 2'(w_snap_drop) + 2'(w_str_drop));
      end
   end

   always_comb begin
      w_tx_nxt     = r_tx_st;
      w_tx_dat     = 8'h00;
      w_start_snap = 1'b0;
      w_start_evt  = 1'b0;
      w_start_str  = 1'b0;
      case (r_tx_st)
         T_IDLE: begin
            if (r_snap_pend)          w_start_snap = 1'b1;
            else if (bus.event_valid) w_start_evt  = 1'b1;
            else if (r_str_pend)      w_start_str  = 1'b1;
            if (r_snap_pend || bus.event_valid || r_str_pend) w_tx_nxt = T_SYNC;
         end
         T_SYNC: begin
            w_tx_dat = SYNC;
            if (bus.tx_ready) w_tx_nxt = T_ID;
         end
         T_ID: begin
            w_tx_dat = r_tx_id;
            if (bus.tx_ready) w_tx_nxt = T_DATA;
         end
         T_DATA: begin
            w_tx_dat = r_tx_buf[7:0];
            if (bus.tx_ready && (r_tx_left == 8'd1)) w_tx_nxt = T_CHK;
         end
         T_CHK: begin
            w_tx_dat = r_tx_sum;
            if (bus.tx_ready) w_tx_nxt = T_IDLE;
         end
         default: w_tx_nxt = T_IDLE;
      endcase
   end

   // Payload is shifted out LSB-first, so the packed channel bus maps directly onto the byte order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_st   <= T_IDLE;
         r_tx_buf  <= '0;
         r_tx_id   <= '0;
         r_tx_sum  <= '0;
         r_tx_left <= '0;
      end else begin
         r_tx_st <= w_tx_nxt;
         if (w_start_snap) begin
            r_tx_buf  <= BUF_W'(bus.ch_data);
            r_tx_id   <= 8'h01;
            r_tx_sum  <= 8'h01;
            r_tx_left <= 8'(NUM_CH * CH_B);
         end else if (w_start_evt) begin
            r_tx_buf  <= BUF_W'(bus.event_data);
            r_tx_id   <= 8'hE1;
            r_tx_sum  <= 8'hE1;
            r_tx_left <= 8'd4;
         end else if (w_start_str) begin
            r_tx_buf  <= BUF_W'(r_str_dat);
            r_tx_id   <= 8'h44;
            r_tx_sum  <= 8'h44;
            r_tx_left <= 8'(CH_B);
         end else if ((r_tx_st == T_DATA) && bus.tx_ready) begin
            r_tx_buf  <= r_tx_buf >> 8;
            r_tx_sum  <= r_tx_sum + r_tx_buf[7:0];
            r_tx_left <= r_tx_left - 8'd1;
         end
      end
   end

   assign bus.tx_valid  = (r_tx_st != T_IDLE);
   assign bus.busy      = (r_tx_st != T_IDLE);
   assign bus.tx_data   = w_tx_dat;
   assign bus.event_ack = (r_tx_st == T_CHK) && bus.tx_ready && (r_tx_id == 8'hE1);
   assign bus.cfg_wr    = r_cfg_wr;
   assign bus.cfg_addr  = r_cfg_addr;
   assign bus.cfg_data  = r_cfg_data;
   assign bus.err_cnt   = r_err_cnt;
   assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_uart_telemetry_ctrl.sv
// Directed bench for uart_telemetry_ctrl: command frames in, TX byte stream captured and compared to hand-built frames.
module tb_uart_telemetry_ctrl;
   localparam int TMO = 16;

   logic clk;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   rdy_mode;
   int   cyc = 0;
   int   cfg_wr_cnt = 0;
   int   ack_cnt = 0;
   logic stalled = 1'b0;
   logic [7:0] stall_dat = 8'h00;

   logic [7:0] txq[$];
   logic       ackq[$];
   int         cycq[$];
   logic [7:0] expq[$];

   uart_telemetry_ctrl_if #(.NUM_CH(8), .CH_W(16)) bus ();

   uart_telemetry_ctrl #(.NUM_CH(8), .CH_W(16), .SYNC(8'hAA), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // tx_ready: 0 = always ready, 1 = toggling, 2 = stalled
   initial begin
      bus.tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 1) bus.tx_ready = ~bus.tx_ready;
         else               bus.tx_ready = (rdy_mode == 0);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (stalled) begin
            check("hold_vld", 64'(bus.tx_valid), 64'(1));
            check("hold_dat", 64'(bus.tx_data), 64'(stall_dat));
         end
         if (bus.tx_valid && bus.tx_ready) begin
            txq.push_back(bus.tx_data);
            ackq.push_back(bus.event_ack);
            cycq.push_back(cyc);
         end
         if (bus.cfg_wr)    cfg_wr_cnt++;
         if (bus.event_ack) ack_cnt++;
         stalled   = bus.tx_valid && !bus.tx_ready && !rst;
         stall_dat = bus.tx_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200us");
      $fatal(1, "watchdog expired");
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic pulse(input int ch, input logic [15:0] v);
      @(negedge clk);
      bus.ch_data[ch*16 +: 16] = v;
      bus.ch_en = 8'(1 << ch);
      @(negedge clk);
      bus.ch_en = '0;
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int k;
      k = 0;
      while (txq.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("tx_count", 64'(txq.size()), 64'(n));
   endtask

   task automatic clear_mon();
      txq.delete();
      ackq.delete();
      cycq.delete();
   endtask

   // Checksum 0x01 + (0+1+..+7) + 8*0x11 = 0xA5
   task automatic push_snap();
      expq.push_back(8'hAA);
      expq.push_back(8'h01);
      for (int k = 0; k < 8; k++) begin
         expq.push_back(8'(k));
         expq.push_back(8'h11);
      end
      expq.push_back(8'hA5);
   endtask

   task automatic cmp_frame(input string tag);
      while (expq.size() > 0) begin
         if (txq.size() == 0) begin
            check({tag, "_len"}, 64'(txq.size()), 64'(expq.size()));
            expq.delete();
         end else begin
            check(tag, 64'(txq.pop_front()), 64'(expq.pop_front()));
         end
      end
   endtask

   initial begin
      int k;
      int n;
      rst = 1'b1;
      rdy_mode = 0;
      bus.rx_valid = 1'b0;
      bus.rx_data = '0;
      bus.ch_data = '0;
      bus.ch_en = '0;
      bus.event_valid = 1'b0;
      bus.event_data = '0;
      repeat (3) @(negedge clk);
      check("rst_tx_valid", 64'(bus.tx_valid), 64'(0));
      check("rst_tx_data", 64'(bus.tx_data), 64'(0));
      check("rst_cfg_wr", 64'(bus.cfg_wr), 64'(0));
      check("rst_cfg_addr", 64'(bus.cfg_addr), 64'(0));
      check("rst_cfg_data", 64'(bus.cfg_data), 64'(0));
      check("rst_event_ack", 64'(bus.event_ack), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_err_cnt", 64'(bus.err_cnt), 64'(0));
      check("rst_drop_cnt", 64'(bus.drop_cnt), 64'(0));
      rst = 1'b0;

      // snapshot, full rate
      for (int c = 0; c < 8; c++) bus.ch_data[c*16 +: 16] = 16'h1100 + 16'(c);
      clear_mon();
      send(8'h01); send(8'h01);
      wait_bytes(19, 100);
      if (cycq.size() >= 19) check("snap_b2b", 64'(cycq[18] - cycq[0]), 64'(18));
      push_snap();
      cmp_frame("snap_byte");
      clear_mon();
      repeat (2) @(negedge clk);
      check("snap_busy_fall", 64'(bus.busy), 64'(0));

      // register write, good and bad checksum
      send(8'h11); send(8'h05); send(8'h3C); send(8'h52);
      check("wr_pulse", 64'(bus.cfg_wr), 64'(1));
      check("wr_addr", 64'(bus.cfg_addr), 64'(8'h05));
      check("wr_data", 64'(bus.cfg_data), 64'(8'h3C));
      @(negedge clk);
      check("wr_one_cycle", 64'(bus.cfg_wr), 64'(0));
      check("wr_err", 64'(bus.err_cnt), 64'(0));
      send(8'h11); send(8'h05); send(8'h3C); send(8'h53);
      repeat (2) @(negedge clk);
      check("bad_chk_no_wr", 64'(cfg_wr_cnt), 64'(1));
      check("bad_chk_err", 64'(bus.err_cnt), 64'(1));

      // stream channel 2 with toggling tx_ready: 0x44+0xEF+0xBE = 0xF1
      rdy_mode = 1;
      send(8'h44); send(8'h02); send(8'h46);
      pulse(2, 16'hBEEF);
      wait_bytes(5, 100);
      expq = '{8'hAA, 8'h44, 8'hEF, 8'hBE, 8'hF1};
      cmp_frame("strm_byte");
      clear_mon();
      repeat (3) @(negedge clk);

      // one sending, one pending, third strobe dropped
      rdy_mode = 2;
      repeat (2) @(negedge clk);
      pulse(2, 16'h1234);
      repeat (4) @(negedge clk);
      pulse(2, 16'h5678);
      repeat (4) @(negedge clk);
      pulse(2, 16'h9ABC);
      @(negedge clk);
      check("strm_drop", 64'(bus.drop_cnt), 64'(1));
      rdy_mode = 0;
      wait_bytes(10, 100);
      expq = '{8'hAA, 8'h44, 8'h34, 8'h12, 8'h8A, 8'hAA, 8'h44, 8'h78, 8'h56, 8'h12};
      cmp_frame("strm_pend");
      clear_mon();

      send(8'h45); send(8'h45);
      pulse(2, 16'h1102);
      repeat (20) @(negedge clk);
      check("strm_off_quiet", 64'(txq.size()), 64'(0));
      check("strm_off_drop", 64'(bus.drop_cnt), 64'(1));

      // event raised during a snapshot response
      clear_mon();
      send(8'h01); send(8'h01);
      k = 0;
      while (!bus.busy && k < 20) begin @(negedge clk); k++; end
      check("evt_busy", 64'(bus.busy), 64'(1));
      bus.event_data  = 32'h04030201;
      bus.event_valid = 1'b1;
      k = 0;
      while (!bus.event_ack && k < 200) begin @(negedge clk); k++; end
      check("evt_ack_seen", 64'(bus.event_ack), 64'(1));
      bus.event_valid = 1'b0;
      wait_bytes(26, 20);
      if (ackq.size() == 26)
         for (int i = 0; i < 26; i++) check("evt_ack_pos", 64'(ackq[i]), 64'(i == 25));
      if (cycq.size() >= 20) check("evt_gap", 64'(cycq[19] - cycq[18]), 64'(2));
      push_snap();
      expq.push_back(8'hAA); expq.push_back(8'hE1); expq.push_back(8'h01);
      expq.push_back(8'h02); expq.push_back(8'h03); expq.push_back(8'h04);
      expq.push_back(8'hEB);
      cmp_frame("evt_frame");
      clear_mon();
      repeat (2) @(negedge clk);
      check("evt_ack_cnt", 64'(ack_cnt), 64'(1));

      // inter-byte timeout: exactly TMO idle cycles
      send(8'h11);
      repeat (TMO - 1) @(negedge clk);
      check("tmo_before", 64'(bus.err_cnt), 64'(1));
      @(negedge clk);
      check("tmo_after", 64'(bus.err_cnt), 64'(2));
      send(8'h01); send(8'h01);
      wait_bytes(19, 100);
      push_snap();
      cmp_frame("tmo_snap");
      clear_mon();

      // byte in the expiry cycle keeps the frame alive
      send(8'h11);
      repeat (TMO - 2) @(negedge clk);
      send(8'h07); send(8'h3C); send(8'h54);
      check("tmo_edge_addr", 64'(bus.cfg_addr), 64'(8'h07));
      check("tmo_edge_data", 64'(bus.cfg_data), 64'(8'h3C));
      check("tmo_edge_err", 64'(bus.err_cnt), 64'(2));

      send(8'h7F);
      check("unknown_op", 64'(bus.err_cnt), 64'(3));
      send(8'h44); send(8'h08); send(8'h4C);
      check("bad_index_err", 64'(bus.err_cnt), 64'(4));
      pulse(0, 16'h1100);
      repeat (10) @(negedge clk);
      check("bad_index_quiet", 64'(txq.size()), 64'(0));

      repeat (300) send(8'h7F);
      check("err_saturate", 64'(bus.err_cnt), 64'(255));

      // reset in the middle of a snapshot frame
      clear_mon();
      send(8'h01); send(8'h01);
      wait_bytes(5, 50);
      rst = 1'b1;
      @(negedge clk);
      check("rstm_tx_valid", 64'(bus.tx_valid), 64'(0));
      check("rstm_tx_data", 64'(bus.tx_data), 64'(0));
      check("rstm_busy", 64'(bus.busy), 64'(0));
      check("rstm_err", 64'(bus.err_cnt), 64'(0));
      check("rstm_drop", 64'(bus.drop_cnt), 64'(0));
      check("rstm_cfg_addr", 64'(bus.cfg_addr), 64'(0));
      check("rstm_cfg_data", 64'(bus.cfg_data), 64'(0));
      n = txq.size();
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("rstm_no_more", 64'(txq.size()), 64'(n));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
